// File: rtl/alu_pkg.sv
// Shared op codes, FSM states and payload types for the arbitrated 4-bit ALU.
package alu_pkg;

  localparam int unsigned DW  = 4;
  localparam int unsigned OPW = 3;

  localparam logic [OPW-1:0] OP_ADD = 3'b000;
  localparam logic [OPW-1:0] OP_SUB = 3'b001;
  localparam logic [OPW-1:0] OP_NOT = 3'b010;
  localparam logic [OPW-1:0] OP_AND = 3'b011;
  localparam logic [OPW-1:0] OP_OR  = 3'b100;
  localparam logic [OPW-1:0] OP_XOR = 3'b101;
  localparam logic [OPW-1:0] OP_LT  = 3'b110;
  localparam logic [OPW-1:0] OP_EQ  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic [DW-1:0]  a;
    logic [DW-1:0]  b;
    logic [OPW-1:0] op;
    logic           id;
  } cmd_t;

  typedef struct packed {
    logic [DW-1:0] f;
    logic          zero;
    logic          over;
    logic          cout;
  } res_t;

endpackage

// File: rtl/alu4.sv
// Purely combinational 4-bit ALU with zero/overflow/carry flags.
module alu4
  import alu_pkg::*;
(
  input  logic [DW-1:0]  a,
  input  logic [DW-1:0]  b,
  input  logic [OPW-1:0] op,
  output logic [DW-1:0]  f,
  output logic           zero,
  output logic           over,
  output logic           cout
);

  logic [DW-1:0] xb;
  logic [DW:0]   sum;
  logic [DW:0]   diff;
  logic          diff_over;

  // Shared adder for add/sub; a separate subtractor feeds the signed compare.
  assign xb        = b ^ {DW{op[0]}};
  assign sum       = {1'b0, a} + {1'b0, xb} + (DW+1)'(op[0]);
  assign diff      = {1'b0, a} + {1'b0, ~b} + (DW+1)'(1);
  assign diff_over = (a[DW-1] == ~b[DW-1]) && (a[DW-1] != diff[DW-1]);

  always_comb begin
    f    = '0;
    over = 1'b0;
    cout = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        f    = sum[DW-1:0];
        cout = sum[DW];
        over = (a[DW-1] == xb[DW-1]) && (a[DW-1] != sum[DW-1]);
      end
      OP_NOT: f = ~a;
      OP_AND: f = a & b;
      OP_OR:  f = a | b;
      OP_XOR: f = a ^ b;
      OP_LT:  f = {(DW-1)'(0), diff[DW-1] ^ diff_over};
      OP_EQ:  f = {(DW-1)'(0), a == b};
    endcase
  end

  assign zero = (f == '0);

endmodule

// File: rtl/alu_arb.sv
// Two-requester arbiter in front of a single 4-bit ALU; one command in flight,
// response held until the consumer takes it.
module alu_arb
  import alu_pkg::*;
#(
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0_valid,
  input  logic           req1_valid,
  output logic           req0_ready,
  output logic           req1_ready,
  input  logic [DW-1:0]  req0_a,
  input  logic [DW-1:0]  req0_b,
  input  logic [DW-1:0]  req1_a,
  input  logic [DW-1:0]  req1_b,
  input  logic [OPW-1:0] req0_op,
  input  logic [OPW-1:0] req1_op,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic           rsp_id,
  output logic [DW-1:0]  rsp_f,
  output logic           rsp_zero,
  output logic           rsp_over,
  output logic           rsp_cout
);

  state_e state_q, state_d;
  cmd_t   cmd_q, cmd_d;
  res_t   res_q, res_d;
  logic   rsp_id_q, rsp_id_d;
  logic   rsp_valid_q, rsp_valid_d;
  logic   last_q, last_d;
  logic   gnt1_c;
  logic   accept_c;
  res_t   alu_res;

  // last_q holds the id served most recently; reset to 1 so requester 0 wins first.
  always_comb begin
    gnt1_c = req1_valid;
    if (req0_valid && req1_valid) begin
      gnt1_c = (FIXED_PRIO != 0) ? 1'b0 : ~last_q;
    end
  end

  assign req0_ready = (state_q == ST_IDLE) && !rst && req0_valid && !gnt1_c;
  assign req1_ready = (state_q == ST_IDLE) && !rst && req1_valid && gnt1_c;
  assign accept_c   = req0_ready || req1_ready;

  alu4 u_alu (
    .a    (cmd_q.a),
    .b    (cmd_q.b),
    .op   (cmd_q.op),
    .f    (alu_res.f),
    .zero (alu_res.zero),
    .over (alu_res.over),
    .cout (alu_res.cout)
  );

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    res_d       = res_q;
    rsp_id_d    = rsp_id_q;
    rsp_valid_d = rsp_valid_q;
    last_d      = last_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          state_d = ST_EXEC;
          cmd_d   = gnt1_c ? '{a: req1_a, b: req1_b, op: req1_op, id: 1'b1}
                           : '{a: req0_a, b: req0_b, op: req0_op, id: 1'b0};
        end
      end
      ST_EXEC: begin
        state_d     = ST_RESP;
        res_d       = alu_res;
        rsp_id_d    = cmd_q.id;
        rsp_valid_d = 1'b1;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
          last_d      = rsp_id_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cmd_q       <= '0;
      res_q       <= '0;
      rsp_id_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      last_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      res_q       <= res_d;
      rsp_id_q    <= rsp_id_d;
      rsp_valid_q <= rsp_valid_d;
      last_q      <= last_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_f     = res_q.f;
  assign rsp_zero  = res_q.zero;
  assign rsp_over  = res_q.over;
  assign rsp_cout  = res_q.cout;

endmodule

// File: tb/tb_alu_arb.sv
// Bench for alu_arb: round-robin instance fully checked, strict-priority instance
// checked for contended grants; both share stimulus.
module tb_alu_arb;

  logic       clk = 1'b0;
  logic       rst;
  logic       v0, v1, rsp_rdy;
  logic [3:0] a0, b0, a1, b1;
  logic [2:0] op0, op1;

  logic       r0_0, r1_0, rv_0, rid_0, rz_0, ro_0, rc_0;
  logic [3:0] rf_0;
  logic       r0_1, r1_1, rv_1, rid_1, rz_1, ro_1, rc_1;
  logic [3:0] rf_1;

  int passed = 0;
  int total  = 0;
  int last_srv = 1;

  always #5 clk = ~clk;

  alu_arb #(.FIXED_PRIO(0)) dut_rr (
    .clk(clk), .rst(rst),
    .req0_valid(v0), .req1_valid(v1), .req0_ready(r0_0), .req1_ready(r1_0),
    .req0_a(a0), .req0_b(b0), .req1_a(a1), .req1_b(b1), .req0_op(op0), .req1_op(op1),
    .rsp_valid(rv_0), .rsp_ready(rsp_rdy), .rsp_id(rid_0), .rsp_f(rf_0),
    .rsp_zero(rz_0), .rsp_over(ro_0), .rsp_cout(rc_0)
  );

  alu_arb #(.FIXED_PRIO(1)) dut_fp (
    .clk(clk), .rst(rst),
    .req0_valid(v0), .req1_valid(v1), .req0_ready(r0_1), .req1_ready(r1_1),
    .req0_a(a0), .req0_b(b0), .req1_a(a1), .req1_b(b1), .req0_op(op0), .req1_op(op1),
    .rsp_valid(rv_1), .rsp_ready(rsp_rdy), .rsp_id(rid_1), .rsp_f(rf_1),
    .rsp_zero(rz_1), .rsp_over(ro_1), .rsp_cout(rc_1)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Arithmetic reference: {f, zero, over, cout} from two's-complement integer rules.
  function automatic logic [6:0] ref_alu(input int a, input int b, input int op);
    int sa, sb, r, f;
    bit c, o;
    sa = (a >= 8) ? a - 16 : a;
    sb = (b >= 8) ? b - 16 : b;
    c = 0; o = 0; f = 0;
    case (op)
      0: begin r = a + b; f = r % 16; c = (r > 15); o = (sa + sb > 7) || (sa + sb < -8); end
      1: begin r = a - b; f = (r + 16) % 16; c = (a >= b); o = (sa - sb > 7) || (sa - sb < -8); end
      2: f = 15 - a;
      3: f = a & b;
      4: f = a | b;
      5: f = a ^ b;
      6: f = (sa < sb) ? 1 : 0;
      default: f = (a == b) ? 1 : 0;
    endcase
    return {4'(f), f == 0, o, c};
  endfunction

  task automatic txn(input bit vv0, input bit vv1,
                     input int ia0, input int ib0, input int iop0,
                     input int ia1, input int ib1, input int iop1,
                     input int stall, input bit scramble);
    int g;
    bit got;
    logic [6:0] exp;
    @(negedge clk);
    v0 = vv0; v1 = vv1; rsp_rdy = 1'b0;
    a0 = 4'(ia0); b0 = 4'(ib0); op0 = 3'(iop0);
    a1 = 4'(ia1); b1 = 4'(ib1); op1 = 3'(iop1);
    #1;
    chk("idle_no_rsp", 16'(rv_0), 16'(0));
    g = (vv0 && vv1) ? 1 - last_srv : (vv1 ? 1 : 0);
    got = 0;
    for (int cyc = 0; cyc < 8 && !got; cyc++) begin
      if (cyc > 0) begin @(negedge clk); #1; end
      if (r0_0 || r1_0) got = 1;
    end
    chk("accept_seen", 16'(got), 16'(1));
    if (!got) begin
      v0 = 1'b0; v1 = 1'b0;
      return;
    end
    chk("grant", 16'({r1_0, r0_0}), (g == 1) ? 16'h2 : 16'h1);
    if (vv0 && vv1) chk("fixed_prio_grant", 16'({r1_1, r0_1}), 16'h1);
    exp = (g == 1) ? ref_alu(ia1, ib1, iop1) : ref_alu(ia0, ib0, iop0);
    @(negedge clk);
    if (scramble) begin
      a0 = 4'($urandom); b0 = 4'($urandom); op0 = 3'($urandom);
      a1 = 4'($urandom); b1 = 4'($urandom); op1 = 3'($urandom);
    end
    #1;
    chk("exec_quiet", 16'({rv_0, r0_0, r1_0}), 16'(0));
    @(negedge clk); #1;
    chk("rsp_valid", 16'(rv_0), 16'(1));
    chk("rsp_data", 16'({rf_0, rz_0, ro_0, rc_0}), 16'(exp));
    chk("rsp_id", 16'(rid_0), 16'(g));
    for (int s = 0; s < stall; s++) begin
      @(negedge clk); #1;
      chk("stall_hold", 16'({rv_0, rid_0, rf_0, rz_0, ro_0, rc_0, r0_0, r1_0}),
          16'({1'b1, 1'(g), exp, 2'b00}));
    end
    rsp_rdy = 1'b1;
    last_srv = g;
  endtask

  initial begin
    int pat;
    rst = 1'b1; v0 = 1'b1; v1 = 1'b1; rsp_rdy = 1'b0;
    a0 = 4'd0; b0 = 4'd0; a1 = 4'd0; b1 = 4'd0; op0 = 3'd0; op1 = 3'd0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_outputs", 16'({rv_0, rid_0, rf_0, rz_0, ro_0, rc_0}), 16'(0));
    chk("reset_readies", 16'({r0_0, r1_0, r0_1, r1_1}), 16'(0));
    v0 = 1'b0; v1 = 1'b0;
    rst = 1'b0;

    txn(1, 0, 7, 1, 0, 0, 0, 0, 0, 0);
    txn(0, 1, 0, 0, 0, 3, 3, 1, 0, 0);
    txn(0, 1, 0, 0, 0, 8, 1, 6, 0, 0);
    for (int i = 0; i < 4; i++)
      txn(1, 1, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 7),
          $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 7), 0, 0);
    txn(1, 0, 5, 9, 5, 0, 0, 0, 5, 0);
    txn(0, 1, 0, 0, 0, 6, 2, 1, 1, 1);
    txn(1, 0, 4, 4, 7, 0, 0, 0, 0, 1);

    // Reset during EXEC: in-flight command dropped, pointer back to favouring 0.
    @(negedge clk);
    rsp_rdy = 1'b0; v0 = 1'b1; v1 = 1'b0; a0 = 4'd2; b0 = 4'd3; op0 = 3'd0;
    #1;
    chk("rst_test_accept", 16'(r0_0), 16'(1));
    @(negedge clk);
    v0 = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_readies_low", 16'({r0_0, r1_0, rv_0}), 16'(0));
    @(negedge clk);
    rst = 1'b0;
    last_srv = 1;
    rsp_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("rst_no_rsp", 16'(rv_0), 16'(0));
    end
    txn(1, 1, 1, 2, 0, 3, 4, 1, 0, 0);

    for (int i = 0; i < 30; i++) begin
      pat = $urandom_range(1, 3);
      txn(pat[0], pat[1], $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 7),
          $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 7),
          $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    @(negedge clk);
    v0 = 1'b0; v1 = 1'b0; rsp_rdy = 1'b0;
    #1;
    chk("final_idle", 16'(rv_0), 16'(0));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/alu_arb.md
ALU_ARB -- requirements
Module: alu_arb

Interface
REQ-001 The block SHALL have parameter FIXED_PRIO, default 0: 0 selects round-robin arbitration, 1 gives requester 0 strict priority.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset that is asynchronous and active-high.
REQ-004 The block SHALL have ports req0_valid/req1_valid, input, 1, meaning requester N presents a command.
REQ-005 The block SHALL have ports req0_ready/req1_ready, output, 1, meaning the command from requester N is accepted this cycle.
REQ-006 The block SHALL have ports req0_a, req0_b, req1_a and req1_b, input, 4, the operands of each requester.
REQ-007 The block SHALL have ports req0_op/req1_op, input, 3, the ALU op code.
REQ-008 The block SHALL have ports rsp_valid, output, 1, and rsp_ready, input, 1, forming the response handshake.
REQ-009 The block SHALL have port rsp_id, output, 1, the index of the requester that owns the response.
REQ-010 The block SHALL have ports rsp_f, output, 4; rsp_zero, rsp_over and rsp_cout, output, 1 each, the result and its flags.

Function
REQ-011 The op codes SHALL be: 000 add, 001 sub, 010 not a, 011 and, 100 or, 101 xor, 110 signed less-than, 111 equal.
REQ-012 Add/sub SHALL compute {cout,f} = a + (b xor {4{op[0]}}) + op[0], with over = (a[3]==xb[3]) && (a[3]!=f[3]).
REQ-013 Less-than SHALL return f = {000, sub_f[3] xor sub_over}, and equal SHALL return f = {000, a==b}.
REQ-014 Cout and over SHALL be 0 for ops 010..111, and zero SHALL equal (f==0) for every op.
REQ-015 The FSM SHALL have states IDLE, EXEC and RESP: IDLE->EXEC on accept, EXEC->RESP unconditionally, and RESP->IDLE when rsp_valid && rsp_ready.
REQ-016 reqN_ready SHALL be high only in IDLE, only for the granted requester, and reqN_ready SHALL be combinational from the valid inputs and the priority pointer.
REQ-017 Grant SHALL go to the only valid requester; when both are valid, it SHALL go to requester 0 if FIXED_PRIO=1, else to the requester not served last.
REQ-018 On accept, the block SHALL register a, b, op and the id; the registers SHALL hold these values stable until the next accept, regardless of later input changes.
REQ-019 In EXEC, the block SHALL register the ALU outputs into rsp_f and the flag registers, so that rsp_valid rises two cycles after the accept edge.
REQ-020 In RESP, rsp_valid SHALL stay high and all rsp_* SHALL stay constant until rsp_ready; a stalled rsp_ready SHALL hold indefinitely.
REQ-021 The round-robin pointer SHALL update to the served id at the response handshake, not at accept.
REQ-022 No new command SHALL be accepted in EXEC or RESP, and the minimum issue interval SHALL be 3 cycles.
REQ-023 A requester dropping valid while not granted SHALL cause no side effect.

Reset
REQ-024 While rst is high, the block SHALL force state=IDLE, rsp_valid=0, rsp_id=0, rsp_f=0, all flags=0 and the round-robin pointer favouring requester 0.
REQ-025 Reset asserted in EXEC or RESP SHALL discard the in-flight command without emitting a response.
REQ-026 The ready outputs SHALL be low while rst is high.

Structure
REQ-027 A shared package alu_pkg SHALL hold the op-code constants and the FSM state enum.
REQ-028 The combinational ALU SHALL be a sub-module alu4 (a, b, op -> f, zero, over, cout), instantiated once and fed from the captured registers.

Verification
REQ-029 The bench SHALL cover: req0 add a=7,b=1 -> rsp_f=8, over=1, cout=0, zero=0, rsp_id=0, with rsp_valid 2 cycles after accept.
REQ-030 The bench SHALL cover: req1 sub a=3,b=3 -> f=0, zero=1, cout=1, over=0; less-than a=1000,b=0001 -> f=0001.
REQ-031 The bench SHALL cover: both valid continuously, FIXED_PRIO=0 -> grants alternate 0,1,0,1; with FIXED_PRIO=1 -> all grants go to 0.
REQ-032 The bench SHALL cover: rsp_ready held low 5 cycles -> rsp_* stable and both readies low throughout, with exactly one response delivered.
REQ-033 The bench SHALL cover: rst pulsed during EXEC -> no rsp_valid and pointer reset, after which the first contended grant goes to 0.
REQ-034 The bench SHALL cover: operands changed the cycle after accept -> response reflects the captured values.
